// File: rtl/adpll_pkg.sv
// Shared ADPLL constants and state encoding used by the reference generator,
// phase detector and DCO.
package adpll_pkg;

    localparam int PERIOD_W   = 10;
    localparam int MIN_PERIOD = 2;
    localparam int MIN_HIGH   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/ref_cfg_shadow.sv
// One-deep config shadow for the reference generator plus clamp arithmetic
// that turns the selected config into the effective period/high of the next period.
module ref_cfg_shadow #(
    parameter int PERIOD_W   = adpll_pkg::PERIOD_W,
    parameter int DEF_PERIOD = 100,
    parameter int DEF_HIGH   = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                idle,
    input  logic                start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_high,
    input  logic [PERIOD_W-1:0] cfg_shift,
    output logic [PERIOD_W-1:0] period_eff,
    output logic [PERIOD_W-1:0] high_eff
);
    import adpll_pkg::*;

    localparam int SW = PERIOD_W + 2;
    localparam logic signed [SW-1:0] P_MIN = SW'(MIN_PERIOD);
    localparam logic signed [SW-1:0] P_MAX = SW'((1 << PERIOD_W) - 1);
    localparam logic [PERIOD_W-1:0]  H_MIN = PERIOD_W'(MIN_HIGH);
    localparam logic [PERIOD_W-1:0]  ONE   = PERIOD_W'(1);

    logic                sh_valid;
    logic [PERIOD_W-1:0] sh_period, sh_high, sh_shift;
    logic [PERIOD_W-1:0] act_period, act_high, act_shift;
    logic                armed;

    logic                accept, bypass, load_sh, use_shift;
    logic [PERIOD_W-1:0] sel_period, sel_high, sel_shift;
    logic signed [SW-1:0] shift_ext, sum;

    assign cfg_ready = !sh_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign bypass    = idle && accept;
    assign load_sh   = sh_valid && (start || idle);

    // Select what the period starting at this edge will use: a cfg arriving
    // straight into an idle block, a pending shadow, or the active set.
    always_comb begin
        sel_period = act_period;
        sel_high   = act_high;
        sel_shift  = act_shift;
        use_shift  = armed;
        if (bypass) begin
            sel_period = cfg_period;
            sel_high   = cfg_high;
            sel_shift  = cfg_shift;
            use_shift  = 1'b1;
        end else if (load_sh) begin
            sel_period = sh_period;
            sel_high   = sh_high;
            sel_shift  = sh_shift;
            use_shift  = 1'b1;
        end
    end

    // Two guard bits keep period+shift exact before clamping.
    always_comb begin
        shift_ext = '0;
        if (use_shift)
            shift_ext = $signed({{2{sel_shift[PERIOD_W-1]}}, sel_shift});
        sum = $signed({2'b00, sel_period}) + shift_ext;
        if (sum < P_MIN)
            period_eff = P_MIN[PERIOD_W-1:0];
        else if (sum > P_MAX)
            period_eff = P_MAX[PERIOD_W-1:0];
        else
            period_eff = sum[PERIOD_W-1:0];

        if (sel_high < H_MIN)
            high_eff = H_MIN;
        else if (sel_high > period_eff - ONE)
            high_eff = period_eff - ONE;
        else
            high_eff = sel_high;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_valid   <= 1'b0;
            sh_period  <= '0;
            sh_high    <= '0;
            sh_shift   <= '0;
            act_period <= PERIOD_W'(DEF_PERIOD);
            act_high   <= PERIOD_W'(DEF_HIGH);
            act_shift  <= '0;
            armed      <= 1'b0;
        end else begin
            if (bypass) begin
                act_period <= cfg_period;
                act_high   <= cfg_high;
                act_shift  <= cfg_shift;
                armed      <= !start;
            end else if (load_sh) begin
                act_period <= sh_period;
                act_high   <= sh_high;
                act_shift  <= sh_shift;
                armed      <= !start;
                sh_valid   <= 1'b0;
            end else if (start) begin
                armed      <= 1'b0;
            end

            if (accept && !idle) begin
                sh_period <= cfg_period;
                sh_high   <= cfg_high;
                sh_shift  <= cfg_shift;
                sh_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ref_signal_gen.sv
// Programmable square-wave reference for the ADPLL phase detector: period/high
// set through a valid/ready port, with a one-shot signed shift for phase steps.
module ref_signal_gen #(
    parameter int PERIOD_W   = adpll_pkg::PERIOD_W,
    parameter int DEF_PERIOD = 100,
    parameter int DEF_HIGH   = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_high,
    input  logic [PERIOD_W-1:0] cfg_shift,
    output logic                ref_signal,
    output logic                ref_rise,
    output logic [PERIOD_W-1:0] cur_period,
    output logic                busy
);
    import adpll_pkg::*;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    state_t              state, next_state;
    logic                start;
    logic [PERIOD_W-1:0] cnt, cur_high;
    logic [PERIOD_W-1:0] period_eff, high_eff;

    ref_cfg_shadow #(
        .PERIOD_W   (PERIOD_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (state == IDLE),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_shift  (cfg_shift),
        .period_eff (period_eff),
        .high_eff   (high_eff)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // start marks every entry to HIGH, i.e. a period boundary.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: if (en) begin
                next_state = HIGH;
                start      = 1'b1;
            end
            HIGH: if (cnt == cur_high - ONE) next_state = LOW;
            LOW: if (cnt == cur_period - ONE) begin
                if (en) begin
                    next_state = HIGH;
                    start      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            cur_period <= PERIOD_W'(DEF_PERIOD);
            cur_high   <= PERIOD_W'(DEF_HIGH);
            ref_signal <= 1'b0;
            ref_rise   <= 1'b0;
        end else begin
            ref_rise   <= start;
            ref_signal <= (next_state == HIGH);
            if (start) begin
                cnt        <= '0;
                cur_period <= period_eff;
                cur_high   <= high_eff;
            end else if (state != IDLE) begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_ref_signal_gen.sv
// Scoreboard bench for ref_signal_gen: a period-level model predicts each
// period's length/high time; a negedge monitor measures and compares them.
module tb_ref_signal_gen;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic [W-1:0] cfg_shift = '0;
    logic         ref_signal, ref_rise, busy;
    logic [W-1:0] cur_period;

    always #5 clk = ~clk;

    ref_signal_gen #(.PERIOD_W(W), .DEF_PERIOD(100), .DEF_HIGH(50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_shift  (cfg_shift),
        .ref_signal (ref_signal),
        .ref_rise   (ref_rise),
        .cur_period (cur_period),
        .busy       (busy)
    );

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: active cfg, pending cfg and whether the shift is still owed.
    int   m_p = 100, m_h = 50, m_s = 0;
    bit   m_arm = 0, m_pend = 0;
    int   pp, ph, ps;
    int   cur_p = 100;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_p = 100; m_h = 50; m_s = 0; m_arm = 0; m_pend = 0; cur_p = 100;
    endfunction

    function automatic void push_next();
        exp_t e;
        int   p, h;
        if (m_pend) begin
            m_p = pp; m_h = ph; m_s = ps; m_arm = 1; m_pend = 0;
        end
        p = m_p + (m_arm ? m_s : 0);
        m_arm = 0;
        if (p < 2) p = 2;
        if (p > 1023) p = 1023;
        h = m_h;
        if (h < 1) h = 1;
        if (h > p - 1) h = p - 1;
        e.p = p;
        e.h = h;
        cur_p = p;
        q.push_back(e);
    endfunction

    task automatic send_cfg(input int p, input int h, input int s);
        cfg_period = p[W-1:0];
        cfg_high   = h[W-1:0];
        cfg_shift  = s[W-1:0];
        cfg_valid  = 1'b1;
        for (int i = 0; i < 2000 && !cfg_ready; i++) tick();
        chk("cfg_ready_wait", int'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        m_pend = 1; pp = p; ph = h; ps = s;
    endtask

    task automatic wait_rise();
        bit seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (ref_rise) begin
                seen = 1;
                break;
            end
        end
        chk("rise_timeout", int'(seen), 1);
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        chk("idle_timeout", int'(seen), 1);
    endtask

    task automatic start_run();
        push_next();
        en = 1'b1;
        tick();
        chk("start_latency", int'(ref_rise), 1);
    endtask

    // Called just after a rise: optionally reconfigure, then continue or stop.
    task automatic after_rise(input int wc, input bit do_cfg, input int p, input int h,
                              input int s, input bit cont);
        repeat (wc) tick();
        if (!cont) en = 1'b0;
        if (do_cfg) send_cfg(p, h, s);
        if (cont) begin
            push_next();
            wait_rise();
        end else begin
            wait_idle();
            chk("idle_ref", int'(ref_signal), 0);
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ref", int'(ref_signal), 0);
        chk("rst_rise", int'(ref_rise), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur_period", int'(cur_period), 100);
    endtask

    // Monitor: measures each period from its rise to the next rise or idle.
    bit   open = 0;
    int   plen = 0, hlen = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            open = 0;
        end else begin
            if (open && (ref_rise || !busy)) begin
                chk("period_len", plen, cur.p);
                chk("high_len", hlen, cur.h);
                open = 0;
            end
            if (ref_rise) begin
                chk("rise_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    chk("cur_period", int'(cur_period), cur.p);
                    chk("rise_high", int'(ref_signal), 1);
                    open = 1;
                    plen = 0;
                    hlen = 0;
                end
            end
            if (open) begin
                plen++;
                if (ref_signal) hlen++;
            end
            if (!busy) chk("idle_low", int'(ref_signal), 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit running;
        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // Defaults, first-rise latency
        start_run();
        after_rise(0, 0, 0, 0, 0, 1);
        after_rise(0, 0, 0, 0, 0, 1);

        // Mid-period cfg waits for the boundary
        repeat (30) tick();
        send_cfg(40, 10, 0);
        chk("ready_low_pending", int'(cfg_ready), 0);
        push_next();
        wait_rise();
        chk("ready_after_load", int'(cfg_ready), 1);
        after_rise(0, 0, 0, 0, 0, 1);

        // One-shot shifts
        after_rise(5, 1, 100, 50, -20, 1);
        after_rise(0, 0, 0, 0, 0, 1);
        after_rise(5, 1, 100, 50, 30, 1);
        after_rise(0, 0, 0, 0, 0, 1);

        // Clamps
        after_rise(0, 1, 1, 0, 0, 1);
        after_rise(0, 0, 0, 0, 0, 1);
        after_rise(0, 1, 10, 15, 0, 1);
        after_rise(0, 1, 1020, 500, 10, 1);
        after_rise(0, 0, 0, 0, 0, 1);
        after_rise(0, 1, 60, 20, 0, 1);

        // en drop mid-period, re-enable, cfg accepted together with en drop
        after_rise(5, 0, 0, 0, 0, 0);
        start_run();
        after_rise(0, 1, 30, 10, -4, 0);
        start_run();
        after_rise(0, 1, 60, 20, 0, 1);

        // Reset mid-HIGH with a pending cfg in the shadow
        send_cfg(30, 10, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        en = 1'b0;
        tick();
        chk_reset_vals();
        rst_n = 1'b1;
        model_reset();
        q.delete();
        tick();
        start_run();
        after_rise(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        running = 0;
        for (int it = 0; it < 20; it++) begin
            int  wc, p, h, s;
            bit  do_c, cont;
            if (!running) begin
                start_run();
                running = 1;
            end
            do_c = (int'($urandom_range(0, 9)) < 7);
            cont = (int'($urandom_range(0, 9)) < 8);
            wc   = (cur_p > 3) ? int'($urandom_range(0, cur_p - 3)) : 0;
            p    = int'($urandom_range(1, 150));
            h    = int'($urandom_range(0, 160));
            s    = int'($urandom_range(0, 60)) - 30;
            after_rise(wc, do_c, p, h, s, cont);
            running = cont;
        end
        if (running) after_rise(0, 0, 0, 0, 0, 0);

        tick();
        tick();
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
